// File: rtl/console_tx_pkg.sv
// Shared definitions for the LC-3 console output port: register addresses,
// the queued command format and the drain FSM state type.
package console_pkg;

  localparam logic [15:0] DSR_ADDR_DEF = 16'hFE04;
  localparam logic [15:0] DDR_ADDR_DEF = 16'hFE06;
  localparam logic [15:0] DCR_ADDR_DEF = 16'hFE08;

  // One queued display command: Kind=0 character, Kind=1 cursor move.
  typedef struct packed {
    logic        Kind;
    logic [11:0] Payload;
  } disp_cmd_t;

  localparam int unsigned CMD_WIDTH = $bits(disp_cmd_t);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } drain_state_t;

endpackage

// File: rtl/console_tx_if.sv
// CPU memory-bus and display-driver signals of the console output port.
// master = CPU/driver side, slave = console_tx.
interface console_tx_if;

  logic [15:0] BusAddr;
  logic [15:0] BusDataIn;
  logic        BusWE;
  logic        BusRE;
  logic        BusHit;
  logic [15:0] BusDataOut;
  logic        DispReady;
  logic        DispCharWE;
  logic [7:0]  DispChar;
  logic        DispAddrWE;
  logic [11:0] DispAddr;

  modport master (
    output BusAddr, BusDataIn, BusWE, BusRE, DispReady,
    input  BusHit, BusDataOut, DispCharWE, DispChar, DispAddrWE, DispAddr
  );

  modport slave (
    input  BusAddr, BusDataIn, BusWE, BusRE, DispReady,
    output BusHit, BusDataOut, DispCharWE, DispChar, DispAddrWE, DispAddr
  );

endinterface

// File: rtl/console_tx_sync_fifo.sv
// Synchronous FIFO with registered pointers/count and a combinational head.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Push,
  input  logic                     Pop,
  input  logic [WIDTH-1:0]         DataIn,
  output logic [WIDTH-1:0]         DataOut,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign Full    = (Count == (AW+1)'(DEPTH));
  assign Empty   = (Count == '0);
  assign doPush  = Push && !Full;
  assign doPop   = Pop && !Empty;
  assign DataOut = mem[rdPtr];

  // Storage array; contents need no reset since Count gates visibility.
  always_ff @(posedge Clk) begin
    if (doPush) begin
      mem[wrPtr] <= DataIn;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

endmodule

// File: rtl/console_tx.sv
// LC-3 memory-mapped console output: DDR/DCR writes are queued as tagged
// commands and drained to the display driver one per 3 cycles under Ready.
// DSR reports FIFO space, sticky overflow and occupancy.
module console_tx
  import console_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DSR_ADDR   = DSR_ADDR_DEF,
  parameter logic [15:0] DDR_ADDR   = DDR_ADDR_DEF,
  parameter logic [15:0] DCR_ADDR   = DCR_ADDR_DEF
) (
  input logic         Clk,
  input logic         Reset,
  console_tx_if.slave Io
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic         isDsr;
  logic         isDdr;
  logic         isDcr;
  logic         pushReq;
  logic         dsrWrite;
  logic         full;
  logic         empty;
  logic [CW-1:0] count;
  logic         pop;
  logic         overflow;
  disp_cmd_t    cmdIn;
  disp_cmd_t    head;
  drain_state_t state;
  drain_state_t stateNext;
  logic         unusedHiData;

  assign isDsr     = (Io.BusAddr == DSR_ADDR);
  assign isDdr     = (Io.BusAddr == DDR_ADDR);
  assign isDcr     = (Io.BusAddr == DCR_ADDR);
  assign Io.BusHit = isDsr || isDdr || isDcr;

  assign pushReq  = Io.BusWE && (isDdr || isDcr);
  assign dsrWrite = Io.BusWE && isDsr;

  // Characters keep only the low byte; cursor moves keep all 12 bits.
  assign cmdIn.Kind    = isDcr;
  assign cmdIn.Payload = isDcr ? Io.BusDataIn[11:0] : {4'h0, Io.BusDataIn[7:0]};
  assign unusedHiData  = ^Io.BusDataIn[15:12];

  sync_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) cmdFifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .Push    (pushReq && !full),
    .Pop     (pop),
    .DataIn  (cmdIn),
    .DataOut (head),
    .Full    (full),
    .Empty   (empty),
    .Count   (count)
  );

  // Sticky overflow: a dropped write sets it, any DSR write clears it, set wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overflow <= 1'b0;
    end else if (pushReq && full) begin
      overflow <= 1'b1;
    end else if (dsrWrite) begin
      overflow <= 1'b0;
    end
  end

  // DSR read path; DDR/DCR and non-hit reads return zero.
  always_comb begin
    Io.BusDataOut = '0;
    if (Io.BusRE && isDsr) begin
      Io.BusDataOut = {~full, overflow, 14'(count)};
    end
  end

  // Drain FSM state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Drain FSM next-state and strobe decode; strobes depend only on state and head.
  always_comb begin
    stateNext     = state;
    pop           = 1'b0;
    Io.DispCharWE = 1'b0;
    Io.DispAddrWE = 1'b0;
    Io.DispChar   = '0;
    Io.DispAddr   = '0;
    unique case (state)
      IDLE: begin
        if (!empty && Io.DispReady) stateNext = ISSUE;
      end
      ISSUE: begin
        stateNext = HOLD;
        pop       = 1'b1;
        if (head.Kind) begin
          Io.DispAddrWE = 1'b1;
          Io.DispAddr   = head.Payload;
        end else begin
          Io.DispCharWE = 1'b1;
          Io.DispChar   = head.Payload[7:0];
        end
      end
      HOLD: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule
